// File: rtl/clock_time_keeper.sv
// MM:SS BCD time-keeping core with a button-driven set mode, a per-digit blink mask
// and a one-clock pulse when the minutes field wraps in run mode.
module clock_time_keeper #(
  parameter int SEC_WRAP = 60,
  parameter int MIN_WRAP = 60
) (
  input  logic        clk,
  input  logic        RESETn,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [15:0] bcd_out,
  output logic [3:0]  blink_mask,
  output logic [1:0]  mode,
  output logic        hour_pulse
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MIN = 2'd1,
    SET_SEC = 2'd2
  } mode_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam logic [7:0] SEC_TOP = 8'(SEC_WRAP - 1);
  localparam logic [7:0] MIN_TOP = 8'(MIN_WRAP - 1);

  mode_t      state, state_n;
  bcd2_t      min_q, min_n, sec_q, sec_n;
  logic       phase_q, phase_n;
  logic       btn_mode_q, btn_inc_q;
  logic       rise_mode, rise_inc;
  logic       hour_n;
  logic [3:0] mask_n;

  // Wrap is decided on the decimal value, so odd moduli such as 24 or 99 work.
  function automatic logic at_top(input bcd2_t v, input logic [7:0] top);
    return (8'(v.tens) * 8'd10 + 8'(v.ones)) == top;
  endfunction

  function automatic bcd2_t bcd_inc(input bcd2_t v, input logic [7:0] top);
    bcd2_t r;
    if (at_top(v, top)) begin
      r = '0;
    end else if (v.ones == 4'd9) begin
      r.tens = v.tens + 4'd1;
      r.ones = 4'd0;
    end else begin
      r.tens = v.tens;
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  assign rise_mode = btn_mode & ~btn_mode_q;
  assign rise_inc  = btn_inc  & ~btn_inc_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_n = state;
    min_n   = min_q;
    sec_n   = sec_q;
    phase_n = phase_q;
    hour_n  = 1'b0;
    mask_n  = 4'b0000;

    unique case (state)
      RUN: begin
        if (tick_1hz) begin
          sec_n = bcd_inc(sec_q, SEC_TOP);
          if (at_top(sec_q, SEC_TOP)) begin
            min_n  = bcd_inc(min_q, MIN_TOP);
            hour_n = at_top(min_q, MIN_TOP);
          end
        end
        if (rise_mode) state_n = SET_MIN;
      end
      SET_MIN: begin
        if (rise_mode)     state_n = SET_SEC;
        else if (rise_inc) min_n   = bcd_inc(min_q, MIN_TOP);
        if (tick_1hz)      phase_n = ~phase_q;
      end
      SET_SEC: begin
        if (rise_mode)     state_n = RUN;
        else if (rise_inc) sec_n   = bcd_inc(sec_q, SEC_TOP);
        if (tick_1hz)      phase_n = ~phase_q;
      end
      default: state_n = RUN;
    endcase

    // A mode change always restarts the blink with the digits visible.
    if (rise_mode) phase_n = 1'b0;

    case (state_n)
      SET_MIN: mask_n = {phase_n, phase_n, 2'b00};
      SET_SEC: mask_n = {2'b00, phase_n, phase_n};
      default: mask_n = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RESETn) begin
      state      <= RUN;
      min_q      <= '0;
      sec_q      <= '0;
      phase_q    <= 1'b0;
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
      hour_pulse <= 1'b0;
      blink_mask <= 4'b0000;
    end else begin
      state      <= state_n;
      min_q      <= min_n;
      sec_q      <= sec_n;
      phase_q    <= phase_n;
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;
      hour_pulse <= hour_n;
      blink_mask <= mask_n;
    end
  end

  assign bcd_out = {min_q, sec_q};
  assign mode    = state;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Self-checking bench for clock_time_keeper: directed scenarios plus randomized
// stimulus compared against an integer minutes/seconds reference model.
module tb_clock_time_keeper;

  localparam int SW = 60;
  localparam int MW = 60;

  logic        clk = 1'b0;
  logic        RESETn;
  logic        tick_1hz, btn_mode, btn_inc;
  logic [15:0] bcd_out;
  logic [3:0]  blink_mask;
  logic [1:0]  mode;
  logic        hour_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: plain integers, mode 0 RUN / 1 SET_MIN / 2 SET_SEC.
  int   m_min, m_sec, m_mode;
  logic m_phase, m_hp, m_bm_q, m_bi_q;

  clock_time_keeper #(.SEC_WRAP(SW), .MIN_WRAP(MW)) dut (
    .clk        (clk),
    .RESETn     (RESETn),
    .tick_1hz   (tick_1hz),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .bcd_out    (bcd_out),
    .blink_mask (blink_mask),
    .mode       (mode),
    .hour_pulse (hour_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_bcd();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
  endfunction

  function automatic logic [3:0] exp_mask();
    if (m_mode == 1) return {m_phase, m_phase, 2'b00};
    if (m_mode == 2) return {2'b00, m_phase, m_phase};
    return 4'b0000;
  endfunction

  // Drive one clock of inputs, advance the model, and land 1 time unit after the edge.
  task automatic step(input logic r, input logic t, input logic bm, input logic bi);
    logic rm, ri;
    RESETn = r; tick_1hz = t; btn_mode = bm; btn_inc = bi;
    if (!r) begin
      m_min = 0; m_sec = 0; m_mode = 0; m_phase = 0; m_hp = 0; m_bm_q = 0; m_bi_q = 0;
    end else begin
      rm = bm && !m_bm_q;
      ri = bi && !m_bi_q;
      m_hp = 0;
      case (m_mode)
        0: begin
          if (t) begin
            m_sec = m_sec + 1;
            if (m_sec == SW) begin
              m_sec = 0;
              m_min = m_min + 1;
              if (m_min == MW) begin m_min = 0; m_hp = 1; end
            end
          end
          if (rm) m_mode = 1;
        end
        1: begin
          if (rm) m_mode = 2;
          else if (ri) m_min = (m_min + 1) % MW;
          if (t) m_phase = !m_phase;
        end
        default: begin
          if (rm) m_mode = 0;
          else if (ri) m_sec = (m_sec + 1) % SW;
          if (t) m_phase = !m_phase;
        end
      endcase
      if (rm) m_phase = 0;
      m_bm_q = bm;
      m_bi_q = bi;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
    end
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (bcd_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_bcd got %h want 0000", bcd_out); end
    tests_run++;
    if (mode !== 2'd0) begin tests_failed++; $display("FAIL reset_mode got %0d want 0", mode); end
    tests_run++;
    if (blink_mask !== 4'b0000) begin tests_failed++; $display("FAIL reset_mask got %b want 0000", blink_mask); end
    tests_run++;
    if (hour_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_hour got %b want 0", hour_pulse); end
  endtask

  task automatic test_run_count();
    int pulses = 0;
    for (int i = 0; i < 60; i++) begin
      step(1, 1, 0, 0);
      if (hour_pulse) pulses++;
      step(1, 0, 0, 0);
      if (hour_pulse) pulses++;
    end
    tests_run++;
    if (bcd_out !== 16'h0100) begin tests_failed++; $display("FAIL run_60_ticks got %h want 0100", bcd_out); end
    tests_run++;
    if (pulses != 0) begin tests_failed++; $display("FAIL run_no_hour got %0d pulses want 0", pulses); end
  endtask

  task automatic test_hour_wrap();
    press_mode();
    press_inc(58);
    press_mode();
    press_inc(59);
    press_mode();
    tests_run++;
    if (bcd_out !== 16'h5959 || mode !== 2'd0) begin
      tests_failed++; $display("FAIL preload got %h mode %0d want 5959 mode 0", bcd_out, mode);
    end
    step(1, 1, 0, 0);
    tests_run++;
    if (bcd_out !== 16'h0000 || hour_pulse !== 1'b1) begin
      tests_failed++; $display("FAIL hour_wrap got %h hp %b want 0000 hp 1", bcd_out, hour_pulse);
    end
    step(1, 0, 0, 0);
    tests_run++;
    if (hour_pulse !== 1'b0) begin tests_failed++; $display("FAIL hour_single got %b want 0", hour_pulse); end
  endtask

  task automatic test_set_min();
    int pulses = 0;
    press_mode();
    tests_run++;
    if (mode !== 2'd1) begin tests_failed++; $display("FAIL enter_set_min got %0d want 1", mode); end
    press_inc(3);
    tests_run++;
    if (bcd_out !== 16'h0300) begin tests_failed++; $display("FAIL min_plus3 got %h want 0300", bcd_out); end
    press_inc(56);
    tests_run++;
    if (bcd_out !== 16'h5900) begin tests_failed++; $display("FAIL min_59 got %h want 5900", bcd_out); end
    step(1, 0, 0, 1);
    if (hour_pulse) pulses++;
    step(1, 0, 0, 0);
    if (hour_pulse) pulses++;
    tests_run++;
    if (bcd_out !== 16'h0000 || pulses != 0) begin
      tests_failed++; $display("FAIL min_wrap got %h pulses %0d want 0000 pulses 0", bcd_out, pulses);
    end
  endtask

  task automatic test_blink();
    logic [3:0] want;
    press_mode();
    tests_run++;
    if (mode !== 2'd2 || blink_mask !== 4'b0000) begin
      tests_failed++; $display("FAIL enter_set_sec got mode %0d mask %b want 2 0000", mode, blink_mask);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      want = (i % 2 == 0) ? 4'b0011 : 4'b0000;
      tests_run++;
      if (blink_mask !== want || bcd_out !== 16'h0000) begin
        tests_failed++; $display("FAIL blink_tick%0d got mask %b bcd %h want %b 0000", i, blink_mask, bcd_out, want);
      end
    end
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    tests_run++;
    if (mode !== 2'd0 || blink_mask !== 4'b0000 || bcd_out !== 16'h0000) begin
      tests_failed++; $display("FAIL exit_set_sec got mode %0d mask %b bcd %h want 0 0000 0000", mode, blink_mask, bcd_out);
    end
    step(1, 0, 0, 0);
  endtask

  task automatic test_simultaneous();
    press_mode();
    step(1, 0, 1, 1);
    tests_run++;
    if (mode !== 2'd2 || bcd_out !== 16'h0000) begin
      tests_failed++; $display("FAIL mode_inc_same_clk got mode %0d bcd %h want 2 0000", mode, bcd_out);
    end
    step(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    tests_run++;
    if (bcd_out !== 16'h0001) begin tests_failed++; $display("FAIL held_inc got %h want 0001", bcd_out); end
    press_mode();
    step(1, 1, 1, 0);
    tests_run++;
    if (mode !== 2'd1 || bcd_out !== 16'h0002) begin
      tests_failed++; $display("FAIL run_mode_tick got mode %0d bcd %h want 1 0002", mode, bcd_out);
    end
    step(1, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_mode();
    press_inc(12);
    press_mode();
    press_inc(34);
    press_mode();
    press_mode();
    tests_run++;
    if (bcd_out !== 16'h1234 || mode !== 2'd1) begin
      tests_failed++; $display("FAIL preload_1234 got %h mode %0d want 1234 mode 1", bcd_out, mode);
    end
    step(0, 0, 0, 1);
    tests_run++;
    if (bcd_out !== 16'h0000 || mode !== 2'd0) begin
      tests_failed++; $display("FAIL reset_mid got %h mode %0d want 0000 mode 0", bcd_out, mode);
    end
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
    tests_run++;
    if (bcd_out !== 16'h0000 || mode !== 2'd0) begin
      tests_failed++; $display("FAIL held_after_reset got %h mode %0d want 0000 mode 0", bcd_out, mode);
    end
    step(1, 0, 0, 0);
  endtask

  task automatic test_random();
    logic bm = 0, bi = 0, r, t;
    int errs = 0;
    for (int i = 0; i < 4000; i++) begin
      t = ($urandom % 3) == 0;
      if ($urandom % 5 == 0) bm = ~bm;
      if ($urandom % 2 == 0) bi = ~bi;
      r = ($urandom % 700) != 0;
      step(r, t, bm, bi);
      tests_run++;
      if (bcd_out !== exp_bcd() || mode !== 2'(m_mode) || blink_mask !== exp_mask() || hour_pulse !== m_hp) begin
        tests_failed++;
        if (errs++ < 10)
          $display("FAIL rand_cyc%0d got bcd %h mode %0d mask %b hp %b want %h %0d %b %b",
                   i, bcd_out, mode, blink_mask, hour_pulse, exp_bcd(), m_mode, exp_mask(), m_hp);
      end
    end
  endtask

  initial begin
    RESETn = 0; tick_1hz = 0; btn_mode = 0; btn_inc = 0;
    test_reset();
    test_run_count();
    test_hour_wrap();
    test_set_min();
    test_blink();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
